mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle data-memory access controller sitting in the MEM stage between the main decoder's memory controls and a variable-latency data memory. On a load or store it latches the request, drives a req/ack handshake to memory, and stalls the pipeline until the access completes. It performs byte-lane steering, load sign/zero extension, misalignment detection and an optional timeout.

## Interface
- `TIMEOUT_CYCLES`, 255: BUSY cycles without `mem_ack` before abort; only used with `MEM_TIMEOUT_EN`.
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Mem_read` in 1: load request from main decoder, MEM-stage instruction.
- `Mem_write` in 1: store request from main decoder, MEM-stage instruction.
- `funct3` in 3: access size/sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr_i` in 32: byte address from ALU.
- `wdata_i` in 32: store data (rs2).
- `stall` out 1: freeze PC and pipeline registers; combinational.
- `rdata_o` out 32: extended load result; registered.
- `rdata_valid` out 1: `rdata_o` valid this cycle; registered.
- `err` out 1: one-cycle pulse on misaligned access, timeout or read+write conflict.
- `mem_req` out 1: request to memory; registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address; `addr_i` with [1:0] forced to 0.
- `mem_wdata` out 32: store data replicated across lanes.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: access complete; `mem_rdata` valid same cycle.
- `mem_rdata` in 32: aligned read word.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - `stall` = `Mem_read` | `Mem_write`.
  - On a legal, aligned request: latch `we`, `mem_addr`, `mem_be`, `mem_wdata`, `funct3` and `addr_i[1:0]`, then go to BUSY.
  - On a misaligned request (halfword with `addr_i[0]`=1, or word with `addr_i[1:0]`≠0): issue no memory request, set `err`=1, `rdata_o`=0, go to DONE.
  - `Mem_read` & `Mem_write` together: same as misaligned (`err`, no request, go to DONE).
  - Illegal `funct3` values (011, 110, 111): treated as misaligned.
- **BUSY**
  - `mem_req`=1 and `stall`=1.
  - On `mem_ack`: deassert `mem_req` at the next edge, capture and extend the load lane into `rdata_o`, set `rdata_valid` (loads only), go to DONE.
  - Request fields stay stable for the whole of BUSY.
- **DONE**
  - Exactly one cycle; `stall`=0, so the pipeline advances at the end of this cycle.
  - `Mem_read`/`Mem_write` are ignored: they belong to the instruction just completed.
  - Next state is IDLE.
  - `rdata_valid` and `err` are high only in DONE.
- **Byte enables:** byte access gives `mem_be` = 0001 << `addr[1:0]`; halfword gives 0011 << `addr[1:0]`; word gives 1111.
- **Write data:** SB replicates `wdata_i[7:0]` ×4; SH replicates `wdata_i[15:0]` ×2; SW passes `wdata_i`.
- **Load extraction:** select lane by latched `addr[1:0]`. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `rdata_o`, `rdata_valid`, `err` all 0. `stall` follows the IDLE equation.
- `rst` in BUSY: next cycle is IDLE with `mem_req`=0. An in-flight ack is discarded, with no `err` and no `rdata_valid`.
- Latency:
  - Cycle 0: IDLE detects the request.
  - Cycle 1: first BUSY cycle with `mem_req`; earliest `mem_ack`.
  - Cycle 2: DONE.
  - Minimum 3 cycles per access, 2 of them stalled. Each extra ack wait cycle adds 1.
- Misaligned or conflicting access: 2 cycles (IDLE then DONE), 1 stalled.
- Back-to-back memory instructions: DONE, IDLE, BUSY; no request is lost.

## Configuration
- `MEM_TIMEOUT_EN` defined: an 8+ bit counter clears on BUSY entry and increments each BUSY cycle without ack. When it reaches `TIMEOUT_CYCLES`:
  - drop `mem_req`, set `err`=1, `rdata_o`=0, `rdata_valid`=0, go to DONE.
  - An ack in the same cycle as the timeout wins: it is a normal completion.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits for `mem_ack` indefinitely and `err` comes only from misalignment or conflict.

## Test plan
- **LW, 0-wait:** LW `addr_i`=0x100, `mem_ack` in cycle 1, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111; `stall` 1,1,0; `rdata_o`=0xDEADBEEF with `rdata_valid` in cycle 2.
- **LB/LBU extension:** LB at 0x103 with `mem_rdata`=0x80123456 → `rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH + 3-cycle wait:** SH `addr_i`=0x202, `wdata_i`=0x0000ABCD, ack after 3 BUSY cycles → `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `stall` high for 4 cycles then low for 1; no `rdata_valid`.
- **Misaligned / conflict:** LW at 0x102 → no `mem_req`, `err` pulse in cycle 1, `stall` 1 then 0. `Mem_read`=`Mem_write`=1 → identical response.
- **Reset mid-access:** assert `rst` in the second BUSY cycle, ack the following cycle → IDLE, `mem_req`=0, ack ignored, no `err`/`rdata_valid`.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** LW with no ack → after 4 BUSY cycles `mem_req` drops, `err`=1, `rdata_o`=0, then IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller driving a req/ack data
// memory port, with lane steering, load extension and misalignment errors.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Mem_read, Mem_write load/store request from the main decoder
//   funct3              access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i, wdata_i     byte address, store data
//   stall               freeze pipeline (combinational)
//   rdata_o/rdata_valid extended load result (registered)
//   err                 one-cycle pulse: misaligned, conflict or timeout
//   mem_req/we/addr/wdata/be, mem_ack/rdata  memory handshake port
//
// Build option: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES
// cycles without mem_ack. Default build waits for mem_ack indefinitely.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall,
  output logic [31:0] rdata_o,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        req_any;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        f3_bad;
  logic        misal;
  logic        req_bad;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign req_any = Mem_read | Mem_write;
  assign is_byte = funct3[1:0] == 2'b00;
  assign is_half = funct3[1:0] == 2'b01;
  assign is_word = funct3 == 3'b010;
  // 011, 110 and 111 have no access size
  assign f3_bad  = (funct3[1:0] == 2'b11)
                 | (funct3 == 3'b110);
  assign misal   = (is_half & addr_i[0])
                 | (is_word & (addr_i[1:0] != 2'b00));
  assign req_bad = (Mem_read & Mem_write)
                 | f3_bad | misal;

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    unique case (1'b1)
      is_byte: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      is_half: begin
        be_new    = 4'b0011 << addr_i[1:0];
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // shift the addressed lane down to bit 0, then extend
  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = lane;
    unique case (1'b1)
      funct3_q[1:0] == 2'b00:
        load_val = {{24{~funct3_q[2] & lane[7]}},
                    lane[7:0]};
      funct3_q[1:0] == 2'b01:
        load_val = {{16{~funct3_q[2] & lane[15]}},
                    lane[15:0]};
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 255) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  // counter holds the ack-less BUSY cycles already spent
  assign timeout = cnt_q == TO_LAST;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    rdata_d       = rdata_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = Mem_write;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            funct3_d    = funct3;
            off_d       = addr_i[1:0];
            state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      BUSY: begin
        // ack wins over a timeout in the same cycle
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) begin
            rdata_d       = load_val;
            rdata_valid_d = 1'b1;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = req_any;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign rdata_o     = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl
// against a size/offset arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_read;
  logic        Mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall;
  logic [31:0] rdata_o;
  logic        rdata_valid;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .Mem_read(Mem_read), .Mem_write(Mem_write),
    .funct3(funct3), .addr_i(addr_i),
    .wdata_i(wdata_i), .stall(stall),
    .rdata_o(rdata_o), .rdata_valid(rdata_valid),
    .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  // per-access observations
  int          o_cycles, o_stall, o_req;
  int          o_rv_cnt, o_err_cnt;
  logic        o_done, o_rv, o_err, o_unstable, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;

  // reference: size from funct3, legality and lanes by arithmetic
  function automatic void model(
    input  logic [2:0]  f3,
    input  logic        rd, wr,
    input  logic [31:0] a, wd, rdat,
    output logic        bad_o,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o, ld_o);
    int sz;
    int off;
    longint raw, lim;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    off   = int'(a % 4);
    bad_o = (rd && wr) || (sz == 0) ||
            ((a % sz) != 0);
    be_o  = 4'(((1 << sz) - 1) << off);
    if (sz == 1)
      wd_o = {24'd0, wd[7:0]} * 32'h01010101;
    else if (sz == 2)
      wd_o = {16'd0, wd[15:0]} * 32'h00010001;
    else
      wd_o = wd;
    ld_o = 32'd0;
    if (sz > 0) begin
      lim = longint'(1) << (8 * sz);
      raw = (longint'(rdat) >> (8 * off)) % lim;
      if (!f3[2] && raw >= (lim / 2))
        raw = raw - lim;
      ld_o = raw[31:0];
    end
  endfunction

  // drive one access, acking in BUSY cycle waits+1; holds the
  // inputs through DONE and returns at the start of the next cycle
  task automatic run_access(
    input logic rd, wr, input logic [2:0] f3,
    input logic [31:0] a, wd, rdat, input int waits);
    int busy;
    busy = 0;
    o_cycles = 0; o_stall = 0; o_req = 0;
    o_rv_cnt = 0; o_err_cnt = 0;
    o_done = 0; o_rv = 0; o_err = 0;
    o_unstable = 0; o_we = 0; o_rdata = 0;
    o_addr = 0; o_wdata = 0; o_be = 0;
    Mem_read = rd; Mem_write = wr;
    funct3 = f3; addr_i = a; wdata_i = wd;
    mem_rdata = rdat; mem_ack = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      o_cycles++;
      if (stall) o_stall++;
      if (rdata_valid) o_rv_cnt++;
      if (err) o_err_cnt++;
      if (mem_req) begin
        busy++;
        o_req++;
        if (busy == 1) begin
          o_addr = mem_addr; o_wdata = mem_wdata;
          o_be = mem_be; o_we = mem_we;
        end else if (o_addr !== mem_addr ||
                     o_wdata !== mem_wdata ||
                     o_be !== mem_be ||
                     o_we !== mem_we) begin
          o_unstable = 1;
        end
        mem_ack = busy > waits;
      end else begin
        mem_ack = 0;
      end
      if (!stall) begin
        o_done = 1; o_rv = rdata_valid;
        o_err = err; o_rdata = rdata_o;
      end
      @(negedge clk);
      if (o_done) break;
    end
    mem_ack = 0;
  endtask

  task automatic idle(input int n);
    Mem_read = 0; Mem_write = 0; mem_ack = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; Mem_read = 0; Mem_write = 0;
    funct3 = 0; addr_i = 0; wdata_i = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata,
         mem_be, rdata_o, rdata_valid, err} !== '0) begin
      bad++;
      $display("FAIL reset_regs got req=%b we=%b a=%h wd=%h be=%b rd=%h rv=%b err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata,
               mem_be, rdata_o, rdata_valid, err);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall0 got=%b want=0", stall);
    end
    Mem_read = 1; #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_stall1 got=%b want=1", stall);
    end
    Mem_read = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 0,
               32'hDEADBEEF, 0);
    total++;
    if (o_done !== 1'b1 || o_cycles != 3) begin
      bad++;
      $display("FAIL lw_cycles got=%0d want=3", o_cycles);
    end
    total++;
    if (o_stall != 2) begin
      bad++;
      $display("FAIL lw_stall got=%0d want=2", o_stall);
    end
    total++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 ||
        o_we !== 1'b0 || o_req != 1) begin
      bad++;
      $display("FAIL lw_req got a=%h be=%b we=%b n=%0d want 100 1111 0 1",
               o_addr, o_be, o_we, o_req);
    end
    total++;
    if (o_rv !== 1'b1 || o_rdata !== 32'hDEADBEEF ||
        o_err !== 1'b0) begin
      bad++;
      $display("FAIL lw_data got rv=%b d=%h err=%b want 1 deadbeef 0",
               o_rv, o_rdata, o_err);
    end
  endtask

  task automatic test_lb_ext();
    run_access(1, 0, 3'b000, 32'h103, 0,
               32'h80123456, 0);
    total++;
    if (o_rv !== 1'b1 || o_rdata !== 32'hFFFFFF80 ||
        o_be !== 4'b1000) begin
      bad++;
      $display("FAIL lb_sign got rv=%b d=%h be=%b want 1 ffffff80 1000",
               o_rv, o_rdata, o_be);
    end
    run_access(1, 0, 3'b100, 32'h103, 0,
               32'h80123456, 1);
    total++;
    if (o_rv !== 1'b1 || o_rdata !== 32'h00000080 ||
        o_stall != 3) begin
      bad++;
      $display("FAIL lbu_zero got rv=%b d=%h st=%0d want 1 00000080 3",
               o_rv, o_rdata, o_stall);
    end
  endtask

  task automatic test_sh_wait();
    run_access(0, 1, 3'b001, 32'h202,
               32'h0000ABCD, 32'h55555555, 2);
    total++;
    if (o_stall != 4 || o_cycles != 5) begin
      bad++;
      $display("FAIL sh_stall got st=%0d cy=%0d want 4 5",
               o_stall, o_cycles);
    end
    total++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD ||
        o_we !== 1'b1 || o_addr !== 32'h200) begin
      bad++;
      $display("FAIL sh_req got be=%b wd=%h we=%b a=%h want 1100 abcdabcd 1 200",
               o_be, o_wdata, o_we, o_addr);
    end
    total++;
    if (o_rv_cnt != 0 || o_err_cnt != 0 ||
        o_unstable !== 1'b0) begin
      bad++;
      $display("FAIL sh_flags got rv=%0d err=%0d unst=%b want 0 0 0",
               o_rv_cnt, o_err_cnt, o_unstable);
    end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 3'b010, 32'h102, 0,
               32'h11111111, 0);
    total++;
    if (o_req != 0 || o_err !== 1'b1 ||
        o_err_cnt != 1 || o_rv_cnt != 0) begin
      bad++;
      $display("FAIL misal_resp got req=%0d err=%b n=%0d rv=%0d want 0 1 1 0",
               o_req, o_err, o_err_cnt, o_rv_cnt);
    end
    total++;
    if (o_stall != 1 || o_cycles != 2 ||
        o_rdata !== 32'h0) begin
      bad++;
      $display("FAIL misal_timing got st=%0d cy=%0d d=%h want 1 2 0",
               o_stall, o_cycles, o_rdata);
    end
  endtask

  task automatic test_conflict();
    run_access(1, 0, 3'b000, 32'h0, 0,
               32'h000000AA, 0);
    run_access(1, 1, 3'b010, 32'h100,
               32'h1234, 0, 0);
    total++;
    if (o_req != 0 || o_err !== 1'b1 ||
        o_stall != 1 || o_cycles != 2 ||
        o_rdata !== 32'h0 || o_rv_cnt != 0) begin
      bad++;
      $display("FAIL conflict got req=%0d err=%b st=%0d cy=%0d d=%h rv=%0d want 0 1 1 2 0 0",
               o_req, o_err, o_stall, o_cycles,
               o_rdata, o_rv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    Mem_read = 1; Mem_write = 0; funct3 = 3'b010;
    addr_i = 32'h40; mem_rdata = 32'h12345678;
    mem_ack = 0;
    @(negedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy got=%b want=1", mem_req);
    end
    @(negedge clk);
    rst = 1; #1;
    total++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy2 got req=%b st=%b want 1 1",
               mem_req, stall);
    end
    @(negedge clk);
    rst = 0; Mem_read = 0; mem_ack = 1; #1;
    total++;
    if (mem_req !== 1'b0 || stall !== 1'b0 ||
        rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_idle got req=%b st=%b d=%h want 0 0 0",
               mem_req, stall, rdata_o);
    end
    @(negedge clk);
    mem_ack = 0; #1;
    total++;
    if (mem_req !== 1'b0 || rdata_valid !== 1'b0 ||
        err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ack got req=%b rv=%b err=%b want 0 0 0",
               mem_req, rdata_valid, err);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_ignored();
    Mem_read = 0; Mem_write = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1; mem_rdata = $urandom;
      @(negedge clk);
      #1;
      total++;
      if (mem_req !== 1'b0 || rdata_valid !== 1'b0 ||
          err !== 1'b0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL ack_idle got req=%b rv=%b err=%b st=%b want 0 0 0 0",
                 mem_req, rdata_valid, err, stall);
      end
    end
    mem_ack = 0;
    @(negedge clk);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1, 0, 3'b010, 32'h300, 0,
               32'hCAFEF00D, 3);
    total++;
    if (o_err !== 1'b0 || o_rv !== 1'b1 ||
        o_rdata !== 32'hCAFEF00D || o_req != 4) begin
      bad++;
      $display("FAIL to_ackwins got err=%b rv=%b d=%h req=%0d want 0 1 cafef00d 4",
               o_err, o_rv, o_rdata, o_req);
    end
    run_access(1, 0, 3'b010, 32'h300, 0,
               32'hCAFEF00D, 1000);
    total++;
    if (o_done !== 1'b1 || o_req != 4 ||
        o_stall != 5 || o_err !== 1'b1 ||
        o_rdata !== 32'h0 || o_rv_cnt != 0) begin
      bad++;
      $display("FAIL to_abort got done=%b req=%0d st=%0d err=%b d=%h rv=%0d want 1 4 5 1 0 0",
               o_done, o_req, o_stall, o_err,
               o_rdata, o_rv_cnt);
    end
    idle(1);
    #1;
    total++;
    if (mem_req !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL to_idle got req=%b err=%b want 0 0",
               mem_req, err);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    logic        rd, wr, xb;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat, ewd, eld;
    logic [3:0]  ebe;
    logic [2:0]  legal [5];
    int          k, w;
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      if ($urandom_range(0, 7) == 0)
        f3 = ($urandom_range(0, 2) == 0) ? 3'd3 :
             ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
      else
        f3 = legal[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd   = $urandom;
      rdat = $urandom;
      w    = $urandom_range(0, 3);
      model(f3, rd, wr, a, wd, rdat, xb, ebe, ewd, eld);
      run_access(rd, wr, f3, a, wd, rdat, w);
      if (xb) begin
        total++;
        if (o_req != 0 || o_err !== 1'b1 ||
            o_stall != 1 || o_cycles != 2 ||
            o_rdata !== 32'h0 || o_rv_cnt != 0) begin
          bad++;
          $display("FAIL rnd_bad i=%0d got req=%0d err=%b st=%0d cy=%0d d=%h want 0 1 1 2 0",
                   i, o_req, o_err, o_stall,
                   o_cycles, o_rdata);
        end
      end else begin
        total++;
        if (o_done !== 1'b1 || o_req != w + 1 ||
            o_stall != w + 2 || o_err_cnt != 0 ||
            o_unstable !== 1'b0) begin
          bad++;
          $display("FAIL rnd_timing i=%0d got req=%0d st=%0d err=%0d unst=%b want %0d %0d 0 0",
                   i, o_req, o_stall, o_err_cnt,
                   o_unstable, w + 1, w + 2);
        end
        total++;
        if (o_addr !== {a[31:2], 2'b00} ||
            o_be !== ebe || o_we !== wr) begin
          bad++;
          $display("FAIL rnd_req i=%0d got a=%h be=%b we=%b want %h %b %b",
                   i, o_addr, o_be, o_we,
                   {a[31:2], 2'b00}, ebe, wr);
        end
        total++;
        if (wr) begin
          if (o_wdata !== ewd || o_rv_cnt != 0) begin
            bad++;
            $display("FAIL rnd_store i=%0d got wd=%h rv=%0d want %h 0",
                     i, o_wdata, o_rv_cnt, ewd);
          end
        end else begin
          if (o_rv !== 1'b1 || o_rv_cnt != 1 ||
              o_rdata !== eld) begin
            bad++;
            $display("FAIL rnd_load i=%0d f3=%0d got rv=%b d=%h want 1 %h",
                     i, f3, o_rv, o_rdata, eld);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_ext();
    test_sh_wait();
    idle(1);
    test_misaligned();
    test_conflict();
    idle(2);
    test_reset_mid();
    test_ack_ignored();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
